// File: rtl/dsi_packet_assembler_if.sv
// dsi_packet_assembler_if: descriptor, payload and lane byte buses of the DSI packet assembler
interface dsi_packet_assembler_if;
  logic        pkt_valid, pkt_ready;
  logic [7:0]  pkt_data_id;
  logic [15:0] pkt_word_count;
  logic        pkt_long, pkt_hs, pkt_eot, pkt_dummy;
  logic        pld_valid, pld_ready;
  logic [7:0]  pld_data;
  logic        lane_data_request, lane_data_write;
  logic [7:0]  lane_data_input;
  logic        lane_data_type, lane_end_of_frame, lane_dummy_frame;
  modport master (
    output pkt_valid, pkt_data_id, pkt_word_count, pkt_long, pkt_hs, pkt_eot, pkt_dummy,
    output pld_valid, pld_data, lane_data_request,
    input  pkt_ready, pld_ready, lane_data_write, lane_data_input, lane_data_type,
    input  lane_end_of_frame, lane_dummy_frame
  );
  modport slave (
    input  pkt_valid, pkt_data_id, pkt_word_count, pkt_long, pkt_hs, pkt_eot, pkt_dummy,
    input  pld_valid, pld_data, lane_data_request,
    output pkt_ready, pld_ready, lane_data_write, lane_data_input, lane_data_type,
    output lane_end_of_frame, lane_dummy_frame
  );
endinterface

// File: rtl/dsi_packet_assembler.sv
// dsi_packet_assembler: builds DSI short/long/dummy packets (header, ECC, payload, CRC-16) as a lane byte stream.
// Define DSI_PKT_CRC_EN to compute the payload CRC; otherwise CRC bytes are sent as 00,00.
module dsi_packet_assembler #(
  parameter int         WC_W       = 16,
  parameter logic [7:0] DUMMY_BYTE = 8'h00
) (
  input logic                  clk_base,
  input logic                  reset_n,
  dsi_packet_assembler_if.slave bus,
  output logic                 busy,
  output logic                 err_underrun
);
  typedef enum logic [3:0] {S_IDLE, S_DUMMY, S_HDR0, S_HDR1, S_HDR2, S_ECC, S_PLD, S_CRC0, S_CRC1} state_t;
  state_t          r_state, w_nxt;
  logic            r_rdy, r_long, r_hs, r_eot;
  logic [7:0]      r_id;
  logic [WC_W-1:0] r_wc, r_cnt;
  logic [15:0]     w_crc;
  logic [23:0]     w_hdr;
  logic [5:0]      w_ecc;
  logic            w_wr;
`ifdef DSI_PKT_CRC_EN
  logic [15:0]     r_crc;
  // byte-wide form of the reflected 0x8408 CRC, equivalent to eight LSB-first bit steps
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c[7:0] ^ d;
    x = x ^ {x[3:0], 4'h0};
    return {x, c[15:8]} ^ {12'h000, x[7:4]} ^ {5'h00, x, 3'b000};
  endfunction
  assign w_crc = r_crc;
`else
  assign w_crc = 16'h0000;
`endif
  assign w_hdr = {r_wc, r_id};
  // each ECC bit is the parity of its Hamming row over the 24 header bits
  assign w_ecc = {^(w_hdr & 24'hEFFC00), ^(w_hdr & 24'hDF03F0), ^(w_hdr & 24'hB8E38E),
                  ^(w_hdr & 24'h749A6D), ^(w_hdr & 24'hF2555B), ^(w_hdr & 24'hF12CB7)};
  assign w_wr = bus.lane_data_request && r_state != S_IDLE && (r_state != S_PLD || bus.pld_valid);
  always_comb
    w_nxt = r_state == S_HDR0 ? S_HDR1 :
            r_state == S_HDR1 ? S_HDR2 :
            r_state == S_HDR2 ? S_ECC :
            r_state == S_ECC  ? (!r_long ? S_IDLE : r_wc == '0 ? S_CRC0 : S_PLD) :
            r_state == S_PLD  ? (r_cnt == WC_W'(1) ? S_CRC0 : S_PLD) :
            r_state == S_CRC0 ? S_CRC1 : S_IDLE;
  always_ff @(posedge clk_base or negedge reset_n)
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_rdy   <= 1'b0;
      r_id    <= '0;
      r_wc    <= '0;
      r_cnt   <= '0;
      r_long  <= 1'b0;
      r_hs    <= 1'b0;
      r_eot   <= 1'b0;
`ifdef DSI_PKT_CRC_EN
      r_crc   <= 16'hFFFF;
`endif
    end else if (r_state == S_IDLE) begin
      if (bus.pkt_valid && r_rdy) begin
        r_state <= bus.pkt_dummy ? S_DUMMY : S_HDR0;
        r_rdy   <= 1'b0;
        r_id    <= bus.pkt_data_id;
        r_wc    <= bus.pkt_word_count;
        r_cnt   <= bus.pkt_word_count;
        r_long  <= bus.pkt_long;
        r_hs    <= bus.pkt_hs;
        r_eot   <= bus.pkt_eot;
`ifdef DSI_PKT_CRC_EN
        r_crc   <= 16'hFFFF;
`endif
      end else
        r_rdy <= 1'b1;
    end else if (w_wr) begin
      r_state <= w_nxt;
      r_rdy   <= w_nxt == S_IDLE;
      if (r_state == S_PLD) begin
        r_cnt <= r_cnt - 1'b1;
`ifdef DSI_PKT_CRC_EN
        r_crc <= crc_upd(r_crc, bus.pld_data);
`endif
      end
    end
  assign bus.pkt_ready         = r_rdy;
  assign bus.pld_ready         = r_state == S_PLD && bus.lane_data_request;
  assign bus.lane_data_write   = w_wr;
  assign bus.lane_data_type    = r_hs;
  assign bus.lane_dummy_frame  = r_state == S_DUMMY;
  assign bus.lane_end_of_frame = r_state == S_DUMMY || (r_eot && (r_state == S_CRC1 || (r_state == S_ECC && !r_long)));
  assign bus.lane_data_input   = r_state == S_DUMMY ? DUMMY_BYTE :
                                 r_state == S_HDR0  ? r_id :
                                 r_state == S_HDR1  ? r_wc[7:0] :
                                 r_state == S_HDR2  ? r_wc[15:8] :
                                 r_state == S_ECC   ? {2'b00, w_ecc} :
                                 r_state == S_PLD   ? bus.pld_data :
                                 r_state == S_CRC0  ? w_crc[7:0] :
                                 r_state == S_CRC1  ? w_crc[15:8] : 8'h00;
  assign busy         = r_state != S_IDLE;
  assign err_underrun = r_state == S_PLD && bus.lane_data_request && !bus.pld_valid;
endmodule

// File: tb/tb_dsi_packet_assembler.sv
// tb_dsi_packet_assembler: directed and random packets checked against a byte-stream model of DSI framing.
module tb_dsi_packet_assembler;
  logic clk_base = 1'b0;
  logic reset_n = 1'b1;
  logic busy, err_underrun;
  int tests = 0, fails = 0, cyc = 0, uf_cnt = 0, acc_cyc = 0;
  logic [10:0] wq[$];
  int          wcyc[$];
  logic [10:0] exp_q[$];
  logic [7:0]  pay[$];
`ifdef DSI_PKT_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif
  // syndrome column of each header bit; ECC is the XOR of the columns of the set bits
  localparam logic [5:0] COL [24] = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                                      6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                                      6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
  dsi_packet_assembler_if bus();
  dsi_packet_assembler dut (.clk_base(clk_base), .reset_n(reset_n), .bus(bus), .busy(busy), .err_underrun(err_underrun));
  always #5 clk_base = ~clk_base;
  always @(posedge clk_base) cyc <= cyc + 1;
  always @(negedge clk_base)
    if (reset_n) begin
      if (err_underrun) uf_cnt++;
      if (bus.lane_data_write) begin
        wq.push_back({bus.lane_data_type, bus.lane_dummy_frame, bus.lane_end_of_frame, bus.lane_data_input});
        wcyc.push_back(cyc);
        tests++;
        assert (bus.lane_data_request === 1'b1)
          else begin fails++; $error("FAIL wr_without_req observed=%0b expected=1", bus.lane_data_request); end
      end
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin fails++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv); end
  endtask
  function automatic logic [5:0] ecc_of(input logic [23:0] d);
    logic [5:0] s = 6'h00;
    for (int i = 0; i < 24; i++) if (d[i]) s ^= COL[i];
    return s;
  endfunction
  function automatic logic [15:0] crc_pay();
    logic [15:0] c = 16'hFFFF;
    foreach (pay[i])
      for (int b = 0; b < 8; b++) c = (c[0] ^ pay[i][b]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    return c;
  endfunction
  task automatic build_exp(input logic [7:0] id, input logic [15:0] wc, input bit lng, hs, eot, dmy);
    logic [15:0] c;
    exp_q.delete();
    if (dmy) exp_q.push_back({hs, 1'b1, 1'b1, 8'h00});
    else begin
      exp_q.push_back({hs, 2'b00, id});
      exp_q.push_back({hs, 2'b00, wc[7:0]});
      exp_q.push_back({hs, 2'b00, wc[15:8]});
      exp_q.push_back({hs, 1'b0, eot && !lng, 2'b00, ecc_of({wc, id})});
      if (lng) begin
        c = CRC_EN ? crc_pay() : 16'h0000;
        foreach (pay[i]) exp_q.push_back({hs, 2'b00, pay[i]});
        exp_q.push_back({hs, 2'b00, c[7:0]});
        exp_q.push_back({hs, 1'b0, eot, c[15:8]});
      end
    end
  endtask
  task automatic fill_rand(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask
  task automatic start_pkt(input logic [7:0] id, input logic [15:0] wc, input bit lng, hs, eot, dmy);
    bit rdy = 1'b0;
    int n = 0;
    bus.pkt_data_id = id;
    bus.pkt_word_count = wc;
    {bus.pkt_long, bus.pkt_hs, bus.pkt_eot, bus.pkt_dummy} = {lng, hs, eot, dmy};
    bus.pkt_valid = 1'b1;
    while (!rdy && n < 100) begin
      @(negedge clk_base);
      rdy = bus.pkt_ready;
      acc_cyc = cyc;
      @(posedge clk_base); #1;
      n++;
    end
    bus.pkt_valid = 1'b0;
    chk("accept", 32'(rdy), 1);
  endtask
  // mode 0: request always high, 1: toggling, 2: random request and payload gaps
  task automatic do_pkt(input string tag, input logic [7:0] id, input logic [15:0] wc, input bit lng, hs, eot, dmy,
                        input int mode, input int stall_at);
    int pi = 0, n = 0, st = 0;
    bit cons, done = 1'b0, rdy_end = 1'b0;
    build_exp(id, wc, lng, hs, eot, dmy);
    wq.delete();
    wcyc.delete();
    uf_cnt = 0;
    start_pkt(id, wc, lng, hs, eot, dmy);
    while (!done && n < 2000) begin
      bus.lane_data_request = mode == 0 ? 1'b1 : mode == 1 ? ~n[0] : ($urandom_range(0, 2) != 0);
      bus.pld_valid = stall_at >= 0 ? !(pi == stall_at && st < 3) : mode == 2 ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.pld_data = pi < pay.size() ? pay[pi] : 8'h00;
      @(negedge clk_base);
      cons = bus.pld_valid && bus.pld_ready;
      if (stall_at >= 0 && pi == stall_at && st < 3) st++;
      done = !busy;
      rdy_end = bus.pkt_ready;
      @(posedge clk_base); #1;
      if (cons) pi++;
      n++;
    end
    bus.lane_data_request = 1'b0;
    bus.pld_valid = 1'b0;
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_rdy_after"}, 32'(rdy_end), 1);
    chk({tag, "_len"}, wq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) chk($sformatf("%s_b%0d", tag, i), 32'(wq[i]), 32'(exp_q[i]));
    if (mode == 0 && stall_at < 0 && wq.size() > 0) begin
      chk({tag, "_first_cyc"}, wcyc[0], acc_cyc + 1);
      chk({tag, "_span"}, wcyc[wcyc.size() - 1] - wcyc[0], wq.size() - 1);
    end
  endtask
  initial begin
    logic [7:0] rid;
    logic [15:0] rwc;
    bit rl, rh, re, rd;
    bus.pkt_valid = 1'b0;
    bus.pkt_data_id = 8'h00;
    bus.pkt_word_count = 16'h0000;
    {bus.pkt_long, bus.pkt_hs, bus.pkt_eot, bus.pkt_dummy} = 4'b0000;
    bus.pld_valid = 1'b0;
    bus.pld_data = 8'h00;
    bus.lane_data_request = 1'b0;
    #2 reset_n = 1'b0;
    #20;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pkt_ready", 32'(bus.pkt_ready), 0);
    chk("rst_write", 32'(bus.lane_data_write), 0);
    chk("rst_data", 32'(bus.lane_data_input), 0);
    chk("rst_flags", 32'({bus.lane_data_type, bus.lane_end_of_frame, bus.lane_dummy_frame, err_underrun}), 0);
    @(posedge clk_base); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk_base);
    #1;
    chk("idle_pkt_ready", 32'(bus.pkt_ready), 1);
    chk("idle_busy", 32'(busy), 0);
    do_pkt("short_0511", 8'h05, 16'h0011, 1'b0, 1'b1, 1'b1, 1'b0, 0, -1);
    chk("short_0511_ecc", 32'(wq[3][7:0]), 32'h36);
    do_pkt("short_0529", 8'h05, 16'h0029, 1'b0, 1'b1, 1'b0, 1'b0, 0, -1);
    chk("short_0529_ecc", 32'(wq[3][7:0]), 32'h1C);
    pay = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    do_pkt("long_check", 8'h39, 16'd9, 1'b1, 1'b1, 1'b1, 1'b0, 0, -1);
    chk("long_check_crc0", 32'(wq[13][7:0]), CRC_EN ? 32'h91 : 32'h00);
    chk("long_check_crc1", 32'(wq[14][7:0]), CRC_EN ? 32'h6F : 32'h00);
    chk("long_check_no_underrun", uf_cnt, 0);
    pay.delete();
    do_pkt("long_empty", 8'h29, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 0, -1);
    chk("long_empty_crc1", 32'(wq[5][7:0]), CRC_EN ? 32'hFF : 32'h00);
    fill_rand(4);
    do_pkt("long_toggle", 8'h39, 16'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1, -1);
    fill_rand(8);
    do_pkt("long_stall", 8'h19, 16'd8, 1'b1, 1'b1, 1'b1, 1'b0, 0, 3);
    chk("underrun_pulses", uf_cnt, 3);
    do_pkt("dummy", 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 0, -1);
    for (int k = 0; k < 15; k++) begin
      rid = 8'($urandom);
      rl = $urandom_range(0, 1) != 0;
      rh = $urandom_range(0, 1) != 0;
      re = $urandom_range(0, 1) != 0;
      rd = $urandom_range(0, 5) == 0;
      rwc = rl ? 16'($urandom_range(0, 24)) : 16'($urandom);
      fill_rand(rl ? int'(rwc) : 0);
      do_pkt($sformatf("rnd%0d", k), rid, rwc, rl, rh, re, rd, 2, -1);
    end
    fill_rand(20);
    start_pkt(8'h29, 16'd20, 1'b1, 1'b1, 1'b1, 1'b0);
    bus.lane_data_request = 1'b1;
    bus.pld_valid = 1'b1;
    bus.pld_data = 8'hA5;
    repeat (6) @(posedge clk_base);
    #3;
    chk("mid_busy_pre", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_write", 32'(bus.lane_data_write), 0);
    chk("mid_rst_ready", 32'({bus.pkt_ready, bus.pld_ready}), 0);
    chk("mid_rst_flags", 32'({bus.lane_data_type, bus.lane_end_of_frame, bus.lane_dummy_frame, err_underrun}), 0);
    chk("mid_rst_data", 32'(bus.lane_data_input), 0);
    bus.lane_data_request = 1'b0;
    bus.pld_valid = 1'b0;
    @(posedge clk_base); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk_base);
    #1;
    do_pkt("after_rst", 8'h05, 16'h0011, 1'b0, 1'b0, 1'b1, 1'b0, 0, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
